data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port MIPS data memory (base 0x1001_0000).
//  Port 0 = CPU load/store path; port 1 = secondary master (loader/debug/DMA).
//  Grants one requester per transaction, drives the memory strobes and returns registered read data.
//  Checks address window and word alignment before any access reaches the memory.
// PARAMETERS
//  DATA_WIDTH    32            data/address width
//  MEMORY_DEPTH  1024          words in the data memory; window = BASE_ADDR .. BASE_ADDR+4*DEPTH-1
//  BASE_ADDR     32'h1001_0000 byte address of word 0
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   synchronous, active-high reset
//  p0_req     in   1   port 0 request; hold high until p0_ack
//  p0_we      in   1   port 0: 1=write, 0=read
//  p0_addr    in   32  port 0 byte address
//  p0_wdata   in   32  port 0 write data
//  p0_ack     out  1   port 0 transaction done, 1-cycle pulse
//  p0_err     out  1   port 0 error, valid with p0_ack
//  p0_rdata   out  32  port 0 read data, valid with p0_ack
//  p1_*       --   --  identical set for port 1 (p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata)
//  mem_addr   out  32  byte address to data memory
//  mem_wdata  out  32  write data to data memory
//  mem_write  out  1   memory write strobe
//  mem_read   out  1   memory read enable
//  mem_rdata  in   32  combinational read data from memory
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE; fixed 3-cycle transaction (req seen cycle 0, ack in cycle 2).
//  - IDLE: if any req, pick winner, latch sel, we, addr, wdata; compute err_q = out-of-window | addr[1:0]!=0.
//  - ACCESS: mem_addr/mem_wdata = latched values; mem_write = we_q & ~err_q; mem_read = ~we_q & ~err_q.
//    Memory writes at the closing edge; mem_rdata captured into rdata_q at the same edge.
//  - RESP: pX_ack=1 for sel only; pX_rdata = rdata_q (0 for writes or err); pX_err = err_q.
//  - Outside ACCESS: mem_write=mem_read=0, mem_addr/mem_wdata hold last latched values.
//  - Non-selected port: ack=0, err=0, rdata=0 at all times.
//  - Window check uses unsigned (addr - BASE_ADDR) >> 2 < MEMORY_DEPTH; addresses below BASE_ADDR wrap large -> err.
//  - Requests are latched in IDLE only. Dropping req after the grant does not cancel the transaction; ack still pulses.
//  - Req still high in the IDLE cycle after ack = new transaction (back-to-back rate: 1 per 3 cycles).
//  - Simultaneous req: arbitration per CONFIGURATION. Loser keeps req high and is served next IDLE if it still wins.
//  - Reset: state=IDLE, all acks/errs=0, rdata_q=0, mem strobes=0, busy=0, last_grant=1, latched regs=0.
//  - Reset in ACCESS: the write strobe is already high at that edge, so the memory write completes.
//    No ack is issued and the FSM returns to IDLE.
// CONFIGURATION
//  DMA_ARB_ROUND_ROBIN_EN defined: round-robin. On simultaneous req, grant the port != last_grant.
//    last_grant updates on every grant; after reset port 0 wins first.
//  Not defined: fixed priority, port 0 always wins. Port 1 can starve; last_grant is unused.
// TESTING
//  1. p0 write 0x1001_0008 <= 0xDEAD_BEEF, then p0 read 0x1001_0008
//     -> mem_write pulses 1 cycle; read ack at cycle 2 with p0_rdata=0xDEAD_BEEF, err=0.
//  2. p1 read 0x1000_FFFC (below window) and p0 read 0x1001_0002 (misaligned)
//     -> each acks with err=1, rdata=0; mem_read/mem_write never assert.
//  3. p0 and p1 req together, held 4 transactions
//     -> RR: grant order 0,1,0,1. Fixed priority: 0,0,0,0 and p1_ack never pulses.
//  4. p0 writes 0x1001_0FFC (last word, DEPTH=1024)
//     -> ok. Write to 0x1001_1000 -> err=1, no strobe.
//  5. reset asserted during ACCESS of a p1 write
//     -> no p1_ack, busy=0 next cycle; memory holds new data. Next p0 req is granted normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Two-port arbiter/sequencer in front of the single-port MIPS
//                data memory. Checks the address window and word alignment,
//                then runs a fixed IDLE -> ACCESS -> RESP transaction.
//                Optional macro DMA_ARB_ROUND_ROBIN_EN selects round-robin
//                arbitration; without it port 0 has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DATA_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic                  p0_err,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DATA_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_err,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic [DATA_WIDTH-1:0] c_DEPTH = DATA_WIDTH'(MEMORY_DEPTH);

    logic [1:0]            r_state;
    logic                  r_sel;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_anyReq;
    logic                  w_grant1;
    logic                  w_reqWe;
    logic [DATA_WIDTH-1:0] w_reqAddr;
    logic [DATA_WIDTH-1:0] w_reqWdata;
    logic [DATA_WIDTH-1:0] w_offset;
    logic                  w_reqErr;
    logic                  w_access;
    logic                  w_resp;

    assign w_anyReq = p0_req | p1_req;

`ifdef DMA_ARB_ROUND_ROBIN_EN
    logic r_lastGrant;
    // On a tie, the port that did not win last time gets the grant.
    assign w_grant1 = p1_req & (~p0_req | ~r_lastGrant);
`else
    assign w_grant1 = p1_req & ~p0_req;
`endif

    assign w_reqWe    = w_grant1 ? p1_we    : p0_we;
    assign w_reqAddr  = w_grant1 ? p1_addr  : p0_addr;
    assign w_reqWdata = w_grant1 ? p1_wdata : p0_wdata;

    // Unsigned subtraction: addresses below the base wrap to huge offsets.
    assign w_offset = w_reqAddr - BASE_ADDR;
    assign w_reqErr = ((w_offset >> 2) >= c_DEPTH) | (w_reqAddr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
`ifdef DMA_ARB_ROUND_ROBIN_EN
            r_lastGrant <= 1'b1;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_anyReq) begin
                        r_sel   <= w_grant1;
                        r_we    <= w_reqWe;
                        r_addr  <= w_reqAddr;
                        r_wdata <= w_reqWdata;
                        r_err   <= w_reqErr;
                        r_state <= c_ACCESS;
`ifdef DMA_ARB_ROUND_ROBIN_EN
                        r_lastGrant <= w_grant1;
`endif
                    end
                end
                c_ACCESS: begin
                    r_rdata <= (r_we | r_err) ? '0 : mem_rdata;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_access = (r_state == c_ACCESS);
    assign w_resp   = (r_state == c_RESP);

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_write = w_access &  r_we & ~r_err;
    assign mem_read  = w_access & ~r_we & ~r_err;
    assign busy      = (r_state != c_IDLE);

    assign p0_ack   = w_resp & ~r_sel;
    assign p0_err   = w_resp & ~r_sel & r_err;
    assign p0_rdata = (w_resp & ~r_sel) ? r_rdata : '0;
    assign p1_ack   = w_resp &  r_sel;
    assign p1_err   = w_resp &  r_sel & r_err;
    assign p1_rdata = (w_resp &  r_sel) ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Self-checking bench for data_mem_arbiter with a behavioural
//                data memory and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int          c_DEPTH = 1024;
    localparam logic [31:0] c_BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, busy;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DATA_WIDTH  (32),
        .MEMORY_DEPTH(c_DEPTH),
        .BASE_ADDR   (c_BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_ack   (p0_ack),
        .p0_err   (p0_err),
        .p0_rdata (p0_rdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_ack   (p1_ack),
        .p1_err   (p1_err),
        .p1_rdata (p1_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_write(mem_write),
        .mem_read (mem_read),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    // Behavioural data memory: combinational read, write on the rising edge.
    logic [31:0] dmem [0:c_DEPTH-1];
    logic        clearMem;
    logic [9:0]  memIdx;
    assign memIdx    = 10'((mem_addr - c_BASE) >> 2);
    assign mem_rdata = dmem[memIdx];
    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < c_DEPTH; i++) dmem[i] <= '0;
        end else if (mem_write) begin
            dmem[memIdx] <= mem_wdata;
        end
    end

    // Reference model state
    logic [31:0] refMem [0:c_DEPTH-1];
    int tests = 0;
    int fails = 0;

    function automatic bit modelErr(input logic [31:0] a);
        longint unsigned la;
        la = longint'(a);
        return (la < longint'(c_BASE)) || (la >= longint'(c_BASE) + 4 * c_DEPTH) || (a % 4 != 0);
    endfunction

    function automatic int modelIdx(input logic [31:0] a);
        return int'((a - c_BASE) / 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setPort(input int port, input bit req, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic txn(input int port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit expErr,
                       input logic [31:0] expRdata, input bit dropReq, input string tag);
        int          cyc;
        bit          gotAck;
        int          nWr, nRd;
        bit          otherBad;
        logic [31:0] seenAddr, gotRd;
        logic        gotErr;
        @(negedge clk);
        setPort(port, 1'b1, we, addr, wdata);
        gotAck = 0; cyc = 0; nWr = 0; nRd = 0; otherBad = 0; seenAddr = '0;
        gotErr = 1'b0; gotRd = '0;
        while (!gotAck && cyc < 6) begin
            @(negedge clk);
            cyc++;
            if (mem_write) nWr++;
            if (mem_read)  nRd++;
            if (mem_write || mem_read) seenAddr = mem_addr;
            if (port == 0) begin
                gotAck = p0_ack; gotErr = p0_err; gotRd = p0_rdata;
                otherBad = otherBad | p1_ack | p1_err | (p1_rdata != 0);
            end else begin
                gotAck = p1_ack; gotErr = p1_err; gotRd = p1_rdata;
                otherBad = otherBad | p0_ack | p0_err | (p0_rdata != 0);
            end
            if (dropReq && cyc == 1) setPort(port, 1'b0, we, addr, wdata);
        end
        setPort(port, 1'b0, we, addr, wdata);
        check({tag, "_ackcycle"}, gotAck ? 32'(cyc) : 32'hFFFF_FFFF, 32'd2);
        check({tag, "_err"}, 32'(gotErr), 32'(expErr));
        check({tag, "_rdata"}, gotRd, expRdata);
        check({tag, "_wrstrobes"}, 32'(nWr), (we && !expErr) ? 32'd1 : 32'd0);
        check({tag, "_rdstrobes"}, 32'(nRd), (!we && !expErr) ? 32'd1 : 32'd0);
        check({tag, "_otherport"}, 32'(otherBad), 32'd0);
        if (!expErr) check({tag, "_memaddr"}, seenAddr, addr);
        if (we && !expErr) refMem[modelIdx(addr)] = wdata;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          expErr;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          order [4];
        int          ackCyc [4];
        int          nAck, cyc, expPort;
        logic [31:0] a, d, expRd;
        bit          we, e;
        int          port, sel;

        vecs[0] = '{0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1] = '{0, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1, 1'b0, 32'h1000_FFFC, 32'h0,         1'b1, 32'h0};
        vecs[3] = '{0, 1'b0, 32'h1001_0002, 32'h0,         1'b1, 32'h0};
        vecs[4] = '{0, 1'b1, 32'h1001_0FFC, 32'h1234_5678, 1'b0, 32'h0};
        vecs[5] = '{0, 1'b0, 32'h1001_0FFC, 32'h0,         1'b0, 32'h1234_5678};
        vecs[6] = '{0, 1'b1, 32'h1001_1000, 32'h0BAD_0BAD, 1'b1, 32'h0};
        vecs[7] = '{1, 1'b1, 32'h1001_0010, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[8] = '{0, 1'b0, 32'h1001_0010, 32'h0,         1'b0, 32'hCAFE_F00D};

        for (int i = 0; i < c_DEPTH; i++) refMem[i] = '0;
        reset = 1'b1; clearMem = 1'b1;
        setPort(0, 1'b0, 1'b0, '0, '0);
        setPort(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0; clearMem = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        check("rst_errs", {30'd0, p0_err, p1_err}, 32'd0);
        check("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
        check("rst_memaddr", mem_addr, 32'd0);
        check("rst_memwdata", mem_wdata, 32'd0);
        check("rst_rdata", p0_rdata | p1_rdata, 32'd0);

        for (int i = 0; i < 9; i++)
            txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].expErr, vecs[i].expRdata, 1'b0, $sformatf("vec%0d", i));

        // Simultaneous requests held across four transactions, right after reset.
        doReset();
        @(negedge clk);
        setPort(0, 1'b1, 1'b0, 32'h1001_0008, '0);
        setPort(1, 1'b1, 1'b0, 32'h1001_0010, '0);
        nAck = 0; cyc = 0;
        while (nAck < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (p0_ack || p1_ack) begin
                order[nAck]  = p1_ack ? 1 : 0;
                ackCyc[nAck] = cyc;
                nAck++;
            end
        end
        setPort(0, 1'b0, 1'b0, '0, '0);
        setPort(1, 1'b0, 1'b0, '0, '0);
        check("arb_ackcount", 32'(nAck), 32'd4);
        for (int i = 0; i < nAck; i++) begin
`ifdef DMA_ARB_ROUND_ROBIN_EN
            expPort = i % 2;
`else
            expPort = 0;
`endif
            check($sformatf("arb_grant%0d", i), 32'(order[i]), 32'(expPort));
            if (i > 0) check($sformatf("arb_gap%0d", i), 32'(ackCyc[i] - ackCyc[i-1]), 32'd3);
        end
        @(negedge clk);

        // Reset during ACCESS of a port 1 write: the write lands, no ack.
        @(negedge clk);
        setPort(1, 1'b1, 1'b1, 32'h1001_0020, 32'h5A5A_A5A5);
        @(negedge clk);
        check("rstacc_busy", 32'(busy), 32'd1);
        check("rstacc_wstrobe", 32'(mem_write), 32'd1);
        reset = 1'b1;
        setPort(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        check("rstacc_busy_after", 32'(busy), 32'd0);
        check("rstacc_noack", {30'd0, p0_ack, p1_ack}, 32'd0);
        refMem[modelIdx(32'h1001_0020)] = 32'h5A5A_A5A5;
        txn(0, 1'b0, 32'h1001_0020, '0, 1'b0, 32'h5A5A_A5A5, 1'b0, "rstacc_read");

        // Randomized single-port transactions against the reference model.
        for (int n = 0; n < 150; n++) begin
            port = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            d    = $urandom;
            sel  = int'($urandom_range(0, 9));
            if (sel < 6)       a = c_BASE + 32'(4 * $urandom_range(0, 15));
            else if (sel == 6) a = c_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if (sel == 7) a = c_BASE - 32'(4 * $urandom_range(1, 100));
            else if (sel == 8) a = c_BASE + 32'(4 * c_DEPTH) + 32'(4 * $urandom_range(0, 100));
            else               a = c_BASE + 32'(4 * (c_DEPTH - 1)) + 32'(4 * $urandom_range(0, 1));
            e     = modelErr(a);
            expRd = (we || e) ? 32'h0 : refMem[modelIdx(a)];
            txn(port, we, a, d, e, expRd, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
